// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse receiver.
package morse_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_LGAP} state_e;

  localparam int DASH_UNITS   = 2;
  localparam int LETTER_UNITS = 2;
  localparam int WORD_UNITS   = 5;
  localparam int SAT_UNITS    = 8;
  localparam int PAT_BITS     = 6;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // bits holds the symbols received so far, 1 = dash, LSB = most recent
  typedef struct packed {
    logic [2:0]          len;
    logic [PAT_BITS-1:0] bits;
  } pattern_t;

  function automatic pattern_t pat_push(input pattern_t p, input logic sym);
    pattern_t r;
    r.len  = p.len + 3'd1;
    r.bits = {p.bits[PAT_BITS-2:0], sym};
    return r;
  endfunction

endpackage

// File: rtl/morse2ascii_lut.sv
// Combinational Morse pattern to ASCII lookup: letters, digits, common punctuation.
module morse2ascii_lut
  import morse_pkg::*;
(
  input  pattern_t   pat,
  output logic       hit,
  output logic [7:0] ascii
);

  // Unused high bits of pat.bits are always zero, so the full word is the key.
  always_comb begin
    hit   = 1'b1;
    ascii = 8'h00;
    case ({pat.len, pat.bits})
      {3'd1, 6'b000000}: ascii = "E";
      {3'd1, 6'b000001}: ascii = "T";
      {3'd2, 6'b000000}: ascii = "I";
      {3'd2, 6'b000001}: ascii = "A";
      {3'd2, 6'b000010}: ascii = "N";
      {3'd2, 6'b000011}: ascii = "M";
      {3'd3, 6'b000000}: ascii = "S";
      {3'd3, 6'b000001}: ascii = "U";
      {3'd3, 6'b000010}: ascii = "R";
      {3'd3, 6'b000011}: ascii = "W";
      {3'd3, 6'b000100}: ascii = "D";
      {3'd3, 6'b000101}: ascii = "K";
      {3'd3, 6'b000110}: ascii = "G";
      {3'd3, 6'b000111}: ascii = "O";
      {3'd4, 6'b000000}: ascii = "H";
      {3'd4, 6'b000001}: ascii = "V";
      {3'd4, 6'b000010}: ascii = "F";
      {3'd4, 6'b000100}: ascii = "L";
      {3'd4, 6'b000110}: ascii = "P";
      {3'd4, 6'b000111}: ascii = "J";
      {3'd4, 6'b001000}: ascii = "B";
      {3'd4, 6'b001001}: ascii = "X";
      {3'd4, 6'b001010}: ascii = "C";
      {3'd4, 6'b001011}: ascii = "Y";
      {3'd4, 6'b001100}: ascii = "Z";
      {3'd4, 6'b001101}: ascii = "Q";
      {3'd5, 6'b011111}: ascii = "0";
      {3'd5, 6'b001111}: ascii = "1";
      {3'd5, 6'b000111}: ascii = "2";
      {3'd5, 6'b000011}: ascii = "3";
      {3'd5, 6'b000001}: ascii = "4";
      {3'd5, 6'b000000}: ascii = "5";
      {3'd5, 6'b010000}: ascii = "6";
      {3'd5, 6'b011000}: ascii = "7";
      {3'd5, 6'b011100}: ascii = "8";
      {3'd5, 6'b011110}: ascii = "9";
      {3'd5, 6'b010010}: ascii = "/";
      {3'd5, 6'b010001}: ascii = "=";
      {3'd5, 6'b001010}: ascii = "+";
      {3'd5, 6'b010110}: ascii = "(";
      {3'd6, 6'b010101}: ascii = ".";
      {3'd6, 6'b110011}: ascii = ",";
      {3'd6, 6'b001100}: ascii = "?";
      {3'd6, 6'b011110}: ascii = "'";
      {3'd6, 6'b100001}: ascii = "-";
      {3'd6, 6'b101101}: ascii = ")";
      {3'd6, 6'b111000}: ascii = ":";
      {3'd6, 6'b011010}: ascii = "@";
      default:           hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_rx.sv
// Morse receiver: times mark/space runs in PRESCALER units, decodes letters to ASCII.
// Optional `MORSE_RX_DEGLITCH_EN filters out runs of at most PRESCALER/4 cycles.
module morse_rx
  import morse_pkg::*;
#(
  parameter int PRESCALER   = 100000,
  parameter int MAX_SYMBOLS = 6
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       morse_in,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       decode_err,
  output logic       overrun,
  output state_e     state_dbg
);

  localparam int CW = $clog2(SAT_UNITS * PRESCALER) + 1;
  localparam logic [CW-1:0] DASH_CNT   = CW'(DASH_UNITS * PRESCALER);
  localparam logic [CW-1:0] LETTER_CNT = CW'(LETTER_UNITS * PRESCALER);
  localparam logic [CW-1:0] WORD_CNT   = CW'(WORD_UNITS * PRESCALER);
  localparam logic [CW-1:0] SAT_CNT    = CW'(SAT_UNITS * PRESCALER);

  logic sync1, m_raw, m;

  // Synchronizer flops are not reset so a line held high across reset stays a mark.
  always_ff @(posedge clk) begin
    sync1 <= morse_in;
    m_raw <= sync1;
  end

`ifdef MORSE_RX_DEGLITCH_EN
  localparam int GLITCH = PRESCALER / 4;
  localparam int GW     = $clog2(GLITCH + 1);
  logic [GW-1:0] g_cnt;

  // m follows m_raw only after the new level has held for GLITCH+1 cycles;
  // both edges are delayed equally, so run lengths are preserved.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      g_cnt <= '0;
      m     <= m_raw;
    end else if (m_raw == m) begin
      g_cnt <= '0;
    end else if (g_cnt == GW'(GLITCH)) begin
      g_cnt <= '0;
      m     <= m_raw;
    end else begin
      g_cnt <= g_cnt + 1'b1;
    end
  end
`else
  assign m = m_raw;
`endif

  state_e         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  pattern_t       pat, pat_n;
  logic           too_long, too_long_n;
  logic           armed;
  logic           emit, err_now;
  logic [7:0]     emit_char;
  logic           lut_hit;
  logic [7:0]     lut_ascii;

  morse2ascii_lut u_lut (
    .pat   (pat),
    .hit   (lut_hit),
    .ascii (lut_ascii)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pat      <= '0;
      too_long <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pat      <= pat_n;
      too_long <= too_long_n;
      armed    <= armed | ~m;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = (cnt == SAT_CNT) ? cnt : cnt + 1'b1;
    pat_n      = pat;
    too_long_n = too_long;
    emit       = 1'b0;
    emit_char  = ASCII_SPACE;
    err_now    = 1'b0;
    case (state)
      S_IDLE: begin
        if (m && armed) begin
          state_n = S_MARK;
          cnt_n   = CW'(1);
        end
      end
      S_MARK: begin
        if (!m) begin
          state_n = S_GAP;
          cnt_n   = CW'(1);
          if (pat.len == 3'(MAX_SYMBOLS)) too_long_n = 1'b1;
          else                            pat_n      = pat_push(pat, cnt >= DASH_CNT);
        end
      end
      S_GAP: begin
        if (m) begin
          state_n = S_MARK;
          cnt_n   = CW'(1);
        end else if (cnt >= LETTER_CNT) begin
          state_n    = S_LGAP;
          pat_n      = '0;
          too_long_n = 1'b0;
          if (lut_hit && !too_long) begin
            emit      = 1'b1;
            emit_char = lut_ascii;
          end else begin
            err_now = 1'b1;
          end
        end
      end
      S_LGAP: begin
        if (m) begin
          state_n = S_MARK;
          cnt_n   = CW'(1);
        end else if (cnt >= WORD_CNT) begin
          state_n = S_IDLE;
          emit    = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output port: a transfer happens on a clk edge where ascii_valid && ascii_ready;
  // ascii_valid never drops without a transfer and ascii_out is stable while valid.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ascii_out   <= 8'h00;
      ascii_valid <= 1'b0;
      decode_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      decode_err <= err_now;
      overrun    <= emit && ascii_valid && !ascii_ready;
      if (emit && (!ascii_valid || ascii_ready)) begin
        ascii_out   <= emit_char;
        ascii_valid <= 1'b1;
      end else if (ascii_valid && ascii_ready) begin
        ascii_valid <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_morse_rx.sv
// Directed and randomized bench for morse_rx with a table-driven Morse reference model.
module tb_morse_rx;
  import morse_pkg::*;

  localparam int P = 4;
`ifdef MORSE_RX_DEGLITCH_EN
  localparam int DG = P / 4 + 1;
`else
  localparam int DG = 0;
`endif
  localparam int LAT = 2 * P + 3 + DG;
  localparam logic [8:0] ERR_EV = 9'h100;

  logic       clk;
  logic       arst_n;
  logic       morse_in;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       decode_err;
  logic       overrun;
  state_e     state_dbg;

  morse_rx #(.PRESCALER(P), .MAX_SYMBOLS(6)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .morse_in    (morse_in),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .decode_err  (decode_err),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference tables: character and its Morse code
  string all_chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.?/@";
  string code_tab[40] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
    ".-.-.-", "..--..", "-..-.", ".--.-."};
  string err_tab[6] = '{"......", ".......", "-------", ".-.-", "..--", "--------"};

  // scoreboard
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int got_rd  = 0;
  int ovr_cnt = 0;
  int n_cmp   = 0;
  int n_err   = 0;

  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      if (ascii_valid === 1'b1 && ascii_ready === 1'b1) got_q.push_back({1'b0, ascii_out});
      if (decode_err === 1'b1) got_q.push_back(ERR_EV);
      if (overrun === 1'b1) ovr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [8:0] e, g;
    chk({tag, "/count"}, 16'(got_q.size() - got_rd), 16'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        g = got_q[got_rd];
        got_rd++;
      end else begin
        g = 9'h1FF;
      end
      chk(tag, {7'd0, g}, {7'd0, e});
    end
    got_rd = got_q.size();
  endtask

  // drivers: called just after a rising edge, hold a level for n cycles
  task automatic level(input logic v, input int n);
    morse_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_code(input string code);
    for (int i = 0; i < code.len(); i++) begin
      if (i > 0) level(1'b0, $urandom_range(2, 2 * P - 1));
      if (code[i] == "-") level(1'b1, $urandom_range(2 * P, 4 * P));
      else                level(1'b1, $urandom_range(2, 2 * P - 1));
    end
  endtask

  initial begin
    int ovr_base;
    int ntok;
    int idx;

    arst_n      = 1'b0;
    morse_in    = 1'b0;
    ascii_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ascii_out", 16'(ascii_out), 16'h00);
    chk("rst_valid", 16'(ascii_valid), 16'h0);
    chk("rst_decode_err", 16'(decode_err), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    chk("rst_state", 16'(state_dbg), 16'(S_IDLE));
    arst_n = 1'b1;

    // leading idle, then E with exact emit latency
    level(1'b0, 20);
    drain("lead_idle");
    level(1'b1, 4);
    level(1'b0, LAT - 1);
    chk("e_latency_pre", 16'(ascii_valid), 16'h0);
    level(1'b0, 1);
    chk("e_latency_valid", 16'(ascii_valid), 16'h1);
    chk("e_latency_char", 16'(ascii_out), 16'h45);
    level(1'b0, 30);
    exp_q.push_back(9'h045);
    exp_q.push_back(9'h020);
    drain("letter_e");

    // A with a long trailing gap: exactly one space
    level(1'b1, 4);
    level(1'b0, 4);
    level(1'b1, 12);
    level(1'b0, 100);
    exp_q.push_back(9'h041);
    exp_q.push_back(9'h020);
    drain("letter_a");

    // seven dots: too long, no character, space still follows
    for (int i = 0; i < 7; i++) begin
      level(1'b1, 4);
      level(1'b0, (i == 6) ? 40 : 4);
    end
    exp_q.push_back(ERR_EV);
    exp_q.push_back(9'h020);
    drain("too_long");

    // holding register full: second E and the space are dropped
    ovr_base    = ovr_cnt;
    ascii_ready = 1'b0;
    level(1'b1, 4);
    level(1'b0, 12);
    level(1'b1, 4);
    level(1'b0, 16);
    chk("ovr_count_1", 16'(ovr_cnt - ovr_base), 16'd1);
    chk("ovr_held_char", 16'(ascii_out), 16'h45);
    chk("ovr_held_valid", 16'(ascii_valid), 16'h1);
    level(1'b0, 30);
    chk("ovr_count_2", 16'(ovr_cnt - ovr_base), 16'd2);
    chk("ovr_held_char2", 16'(ascii_out), 16'h45);
    ascii_ready = 1'b1;
    level(1'b0, 2);
    chk("ovr_drained", 16'(ascii_valid), 16'h0);
    exp_q.push_back(9'h045);
    drain("overrun");

    // reset in the middle of a mark, release while the line is still high
    level(1'b1, 6);
    arst_n = 1'b0;
    level(1'b1, 3);
    chk("midmark_rst_valid", 16'(ascii_valid), 16'h0);
    arst_n = 1'b1;
    level(1'b1, 10);
    chk("midmark_unarmed", 16'(state_dbg), 16'(S_IDLE));
    level(1'b0, 40);
    drain("midmark_silent");
    level(1'b1, 12);
    level(1'b0, 40);
    exp_q.push_back(9'h054);
    exp_q.push_back(9'h020);
    drain("after_reset_t");

    // stuck-high mark saturates and reads as a dash
    level(1'b1, 45);
    level(1'b0, 40);
    exp_q.push_back(9'h054);
    exp_q.push_back(9'h020);
    drain("stuck_high");

    // one-cycle low glitch inside a 12-cycle mark
    level(1'b1, 6);
    level(1'b0, 1);
    level(1'b1, 5);
    level(1'b0, 40);
`ifdef MORSE_RX_DEGLITCH_EN
    exp_q.push_back(9'h054);
`else
    exp_q.push_back(9'h049);
`endif
    exp_q.push_back(9'h020);
    drain("glitch");

    // randomized words with jittered timing, including undecodable patterns
    for (int w = 0; w < 10; w++) begin
      ntok = $urandom_range(1, 4);
      for (int t = 0; t < ntok; t++) begin
        if (t > 0) level(1'b0, $urandom_range(2 * P + 2, 5 * P - 1));
        if ($urandom_range(0, 6) == 0) begin
          idx = $urandom_range(0, 5);
          send_code(err_tab[idx]);
          exp_q.push_back(ERR_EV);
        end else begin
          idx = $urandom_range(0, 39);
          send_code(code_tab[idx]);
          exp_q.push_back({1'b0, all_chars[idx]});
        end
      end
      level(1'b0, $urandom_range(5 * P + 8, 8 * P + 8));
      exp_q.push_back(9'h020);
    end
    level(1'b0, 4);
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
